// File: rtl/terminal_ctrl.sv
// terminal_ctrl: interprets a byte stream (printables, control codes, ESC row/col addressing)
// and drives the terminal core's strobed write port, keeping a shadow copy of the cursor.
module terminal_ctrl #(
  parameter int unsigned STROBE_HI = 4,
  parameter int unsigned STROBE_LO = 4,
  parameter int unsigned ROWS      = 30,
  parameter int unsigned COLS      = 80
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] data,
  output logic [1:0] dtype,
  output logic       dstrobe,
  output logic       busy,
  output logic [4:0] row,
  output logic [6:0] col
);

  localparam logic [1:0]  TypeChar = 2'd0;
  localparam logic [1:0]  TypeCol  = 2'd1;
  localparam logic [1:0]  TypeRow  = 2'd2;
  localparam logic [7:0]  LastRow  = 8'(ROWS - 1);
  localparam logic [7:0]  LastCol  = 8'(COLS - 1);
  localparam logic [11:0] ClrLast  = 12'(ROWS * COLS + 3);
  localparam logic [7:0]  HiLoad   = 8'(STROBE_HI - 1);
  localparam logic [7:0]  LoLoad   = 8'(STROBE_LO - 1);

  typedef enum logic [2:0] {StInit, StIdle, StEscRow, StEscCol, StExec} state_e;
  typedef enum logic [1:0] {PhLoad, PhSetup, PhHi, PhLo} phase_e;
  typedef enum logic [2:0] {SeqChar, SeqCol, SeqRow, SeqBs, SeqEsc, SeqClr} seq_e;

  state_e      state_q, state_d;
  phase_e      phase_q, phase_d;
  seq_e        seq_q, seq_d;
  logic [11:0] step_q, step_d;
  logic [7:0]  arg_q, arg_d, arg2_q, arg2_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  data_q, data_d;
  logic [1:0]  dtype_q, dtype_d;
  logic        dstrobe_q, dstrobe_d;
  logic [4:0]  row_q, row_d;
  logic [6:0]  col_q, col_d;

  logic        start;
  logic [9:0]  cur_op, nxt_op;
  logic [7:0]  ht_raw, ht_col, lf_row, bs_col, esc_row, esc_col;

  // Op list of each sequence, indexed by step; result is {dtype, data}.
  function automatic logic [9:0] op_of(seq_e s, logic [11:0] step, logic [7:0] a,
                                       logic [7:0] b);
    logic [9:0] op;
    op = {TypeChar, a};
    case (s)
      SeqChar: op = {TypeChar, a};
      SeqCol:  op = {TypeCol, a};
      SeqRow:  op = {TypeRow, a};
      SeqBs:   op = (step == 12'd1) ? {TypeChar, 8'h20} : {TypeCol, a};
      SeqEsc:  op = (step == 12'd0) ? {TypeRow, a} : {TypeCol, b};
      SeqClr: begin
        if (step == 12'd0 || step == ClrLast - 12'd1) op = {TypeRow, 8'h00};
        else if (step == 12'd1 || step == ClrLast)    op = {TypeCol, 8'h00};
        else                                          op = {TypeChar, 8'h20};
      end
      default: op = {TypeChar, a};
    endcase
    return op;
  endfunction

  function automatic logic [11:0] last_of(seq_e s);
    logic [11:0] l;
    case (s)
      SeqBs:   l = 12'd2;
      SeqEsc:  l = 12'd1;
      SeqClr:  l = ClrLast;
      default: l = 12'd0;
    endcase
    return l;
  endfunction

  assign cur_op  = op_of(seq_q, step_q, arg_q, arg2_q);
  assign nxt_op  = op_of(seq_q, step_q + 12'd1, arg_q, arg2_q);
  assign ht_raw  = {1'b0, col_q | 7'd7} + 8'd1;
  assign ht_col  = (ht_raw > LastCol) ? LastCol : ht_raw;
  assign lf_row  = ({3'b000, row_q} == LastRow) ? 8'd0 : {3'b000, row_q} + 8'd1;
  assign bs_col  = {1'b0, col_q} - 8'd1;
  assign esc_row = (in_data > LastRow) ? LastRow : in_data;
  assign esc_col = (in_data > LastCol) ? LastCol : in_data;

  assign in_ready = (state_q == StIdle) || (state_q == StEscRow) || (state_q == StEscCol);
  assign busy     = (state_q == StInit) || (state_q == StExec);
  assign data     = data_q;
  assign dtype    = dtype_q;
  assign dstrobe  = dstrobe_q;
  assign row      = row_q;
  assign col      = col_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    seq_d     = seq_q;
    step_d    = step_q;
    arg_d     = arg_q;
    arg2_d    = arg2_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    dtype_d   = dtype_q;
    dstrobe_d = dstrobe_q;
    row_d     = row_q;
    col_d     = col_q;
    start     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_data >= 8'h20 && in_data != 8'h7F) begin
            seq_d = SeqChar;
            arg_d = in_data;
            start = 1'b1;
          end else begin
            case (in_data)
              8'h0D: begin seq_d = SeqCol; arg_d = 8'd0;   start = 1'b1; end
              8'h0A: begin seq_d = SeqRow; arg_d = lf_row; start = 1'b1; end
              8'h09: begin seq_d = SeqCol; arg_d = ht_col; start = 1'b1; end
              8'h0C: begin seq_d = SeqClr; start = 1'b1; end
              8'h1B: state_d = StEscRow;
              8'h08: begin
                if (col_q != 7'd0) begin
                  seq_d = SeqBs;
                  arg_d = bs_col;
                  start = 1'b1;
                end
              end
              default: ;
            endcase
          end
        end
      end
      StEscRow: begin
        if (in_valid) begin
          arg_d   = esc_row;
          state_d = StEscCol;
        end
      end
      StEscCol: begin
        if (in_valid) begin
          arg2_d = esc_col;
          seq_d  = SeqEsc;
          start  = 1'b1;
        end
      end
      StInit, StExec: begin
        unique case (phase_q)
          PhLoad: begin
            {dtype_d, data_d} = cur_op;
            phase_d = PhSetup;
          end
          PhSetup: begin
            dstrobe_d = 1'b1;
            cnt_d     = HiLoad;
            phase_d   = PhHi;
            // Shadow cursor follows the core, which acts on this rising edge.
            case (dtype_q)
              TypeRow: row_d = data_q[4:0];
              TypeCol: col_d = data_q[6:0];
              default: begin
                if ({1'b0, col_q} == LastCol) begin
                  col_d = 7'd0;
                  row_d = ({3'b000, row_q} == LastRow) ? 5'd0 : row_q + 5'd1;
                end else begin
                  col_d = col_q + 7'd1;
                end
              end
            endcase
          end
          PhHi: begin
            if (cnt_q == 8'd0) begin
              dstrobe_d = 1'b0;
              cnt_d     = LoLoad;
              phase_d   = PhLo;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
          PhLo: begin
            if (cnt_q != 8'd0) begin
              cnt_d = cnt_q - 8'd1;
            end else if (step_q == last_of(seq_q)) begin
              state_d = StIdle;
            end else begin
              step_d            = step_q + 12'd1;
              {dtype_d, data_d} = nxt_op;
              phase_d           = PhSetup;
            end
          end
          default: phase_d = PhLoad;
        endcase
      end
      default: state_d = StInit;
    endcase

    if (start) begin
      state_d = StExec;
      phase_d = PhLoad;
      step_d  = 12'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      // INIT reuses the escape sequence with target (0,0).
      state_q   <= StInit;
      phase_q   <= PhLoad;
      seq_q     <= SeqEsc;
      step_q    <= 12'd0;
      arg_q     <= 8'd0;
      arg2_q    <= 8'd0;
      cnt_q     <= 8'd0;
      data_q    <= 8'd0;
      dtype_q   <= 2'd0;
      dstrobe_q <= 1'b0;
      row_q     <= 5'd0;
      col_q     <= 7'd0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      seq_q     <= seq_d;
      step_q    <= step_d;
      arg_q     <= arg_d;
      arg2_q    <= arg2_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      dtype_q   <= dtype_d;
      dstrobe_q <= dstrobe_d;
      row_q     <= row_d;
      col_q     <= col_d;
    end
  end

endmodule

// File: tb/tb_terminal_ctrl.sv
// Bench for terminal_ctrl: directed and random bytes checked against a cursor-level model of
// the op lists each byte should produce, including strobe timing and ready latency.
module tb_terminal_ctrl;

  localparam int Rows  = 30;
  localparam int Cols  = 80;
  localparam int Hi    = 4;
  localparam int Lo    = 4;
  localparam int OpLen = 1 + Hi + Lo;
  localparam int Bound = 30000;

  typedef struct {
    int         e;
    logic [1:0] t;
    logic [7:0] d;
  } op_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;
  logic       in_ready, dstrobe, busy;
  logic [7:0] data;
  logic [1:0] dtype;
  logic [4:0] row;
  logic [6:0] col;

  op_t        got_q[$];
  logic [9:0] exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         edge_cnt = 0;
  int         mr = 0, mc = 0, mesc = 0, mesc_r = 0;
  logic       prev_stb = 1'b0;
  logic [9:0] prev_op = 10'd0;

  terminal_ctrl #(
    .STROBE_HI(Hi),
    .STROBE_LO(Lo),
    .ROWS     (Rows),
    .COLS     (Cols)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data    (data),
    .dtype   (dtype),
    .dstrobe (dstrobe),
    .busy    (busy),
    .row     (row),
    .col     (col)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Capture every strobe rising edge; the cycle before must be a setup with the same op.
  always @(negedge clk) begin : mon
    op_t o;
    if (dstrobe === 1'b1 && prev_stb === 1'b0) begin
      chk("setup_before_rise", {22'd0, prev_op}, {22'd0, dtype, data});
      o.e = edge_cnt;
      o.t = dtype;
      o.d = data;
      got_q.push_back(o);
    end
    prev_stb <= dstrobe;
    prev_op  <= {dtype, data};
  end

  task automatic push(input logic [1:0] t, input int d);
    exp_q.push_back({t, 8'(d)});
  endtask

  // Cursor-level model: what the core's cursor should become and which ops get there.
  task automatic model(input logic [7:0] b);
    int bi, h;
    bi = int'(b);
    if (mesc == 1) begin
      mesc_r = (bi > Rows - 1) ? Rows - 1 : bi;
      mesc   = 2;
    end else if (mesc == 2) begin
      mr   = mesc_r;
      mc   = (bi > Cols - 1) ? Cols - 1 : bi;
      mesc = 0;
      push(2'd2, mr);
      push(2'd1, mc);
    end else if (bi >= 32 && bi != 127) begin
      push(2'd0, bi);
      mc++;
      if (mc == Cols) begin
        mc = 0;
        mr = (mr + 1) % Rows;
      end
    end else begin
      case (bi)
        13: begin mc = 0; push(2'd1, 0); end
        10: begin mr = (mr + 1) % Rows; push(2'd2, mr); end
        8: begin
          if (mc > 0) begin
            mc--;
            push(2'd1, mc);
            push(2'd0, 32);
            push(2'd1, mc);
          end
        end
        9: begin
          h  = (mc | 7) + 1;
          mc = (h > Cols - 1) ? Cols - 1 : h;
          push(2'd1, mc);
        end
        12: begin
          push(2'd2, 0);
          push(2'd1, 0);
          for (int i = 0; i < Rows * Cols; i++) push(2'd0, 32);
          push(2'd2, 0);
          push(2'd1, 0);
          mr = 0;
          mc = 0;
        end
        27: mesc = 1;
        default: ;
      endcase
    end
  endtask

  // Wait for ready, then compare captured ops (value and rise time) and cursor.
  task automatic drain(input int t, input int n);
    int  w;
    op_t o;
    logic [9:0] e;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (in_ready !== 1'b1 && w < Bound);
    chk("ready_latency", edge_cnt, t + 1 + OpLen * n);
    chk("busy_idle", busy, 1'b0);
    chk("op_count", got_q.size(), n);
    for (int i = 0; i < n; i++) begin
      if (got_q.size() == 0) break;
      o = got_q.pop_front();
      e = exp_q.pop_front();
      chk("op_value", {22'd0, o.t, o.d}, {22'd0, e});
      chk("op_rise_time", o.e, t + 2 + OpLen * i);
    end
    chk("row", row, mr);
    chk("col", col, mc);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic send(input logic [7:0] b);
    int t, n, w;
    @(negedge clk);
    w = 0;
    while (in_ready !== 1'b1 && w < Bound) begin
      @(negedge clk);
      w++;
    end
    chk("ready_before_send", in_ready, 1'b1);
    in_data  = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    t = edge_cnt;
    model(b);
    n = exp_q.size();
    if (n == 0) begin
      chk("noop_ready_held", in_ready, 1'b1);
      chk("noop_no_strobe", got_q.size(), 0);
      chk("row", row, mr);
      chk("col", col, mc);
      exp_q.delete();
    end else begin
      drain(t, n);
    end
  endtask

  task automatic do_reset();
    int t;
    @(negedge clk);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_strobe_next_edge", dstrobe, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_dstrobe", dstrobe, 1'b0);
    chk("rst_data", data, 8'd0);
    chk("rst_dtype", dtype, 2'd0);
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_busy", busy, 1'b1);
    chk("rst_row", row, 5'd0);
    chk("rst_col", col, 7'd0);
    got_q.delete();
    exp_q.delete();
    mr = 0; mc = 0; mesc = 0;
    reset_n = 1'b1;
    t = edge_cnt;
    push(2'd2, 0);
    push(2'd1, 0);
    drain(t, 2);
  endtask

  initial begin
    logic [7:0] b;
    int w;
    do_reset();

    send(8'h41);
    chk("print_col", col, 7'd1);

    send(8'h1B); send(8'd29); send(8'd79); send(8'h42);
    chk("wrap_row", row, 5'd0);
    chk("wrap_col", col, 7'd0);

    send(8'h1B); send(8'd0); send(8'd5); send(8'h08);
    chk("bs_col", col, 7'd4);
    send(8'h1B); send(8'd0); send(8'd0); send(8'h08);
    send(8'h1B); send(8'd0); send(8'd10); send(8'h09);
    chk("ht_col", col, 7'd16);
    send(8'h1B); send(8'd0); send(8'd78); send(8'h09);
    chk("ht_clamp_col", col, 7'd79);
    send(8'h0D); send(8'h0A);

    send(8'h1B); send(8'd40); send(8'd200);
    chk("clamp_row", row, 5'd29);
    chk("clamp_col", col, 7'd79);

    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 5))
        0: b = 8'h1B;
        1: b = 8'($urandom_range(8, 13));
        default: b = 8'($urandom_range(0, 255));
      endcase
      if (b == 8'h0C) b = 8'h0D;
      send(b);
    end

    send(8'h0C);
    chk("clear_row", row, 5'd0);
    chk("clear_col", col, 7'd0);

    // Start another clear and pull reset while a strobe is high.
    @(negedge clk);
    in_data  = 8'h0C;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (300) @(negedge clk);
    w = 0;
    while (dstrobe !== 1'b1 && w < 20) begin
      @(negedge clk);
      w++;
    end
    chk("strobe_high_before_reset", dstrobe, 1'b1);
    do_reset();
    send(8'h5A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/terminal_ctrl.md
# terminal_ctrl

Byte-stream controller for the VGA text terminal. Accepts one byte at a time over a valid/ready handshake and interprets it as a printable character, a control code, or an escape cursor-address sequence. Drives the terminal core's `data`/`dtype`/`dstrobe` write port with correctly timed strobe pulses, and keeps a shadow copy of the cursor position. Sits between the CPU or UART byte source and the terminal core, in the 100 MHz domain.

## Interface
Parameters:
- `STROBE_HI`, default 4: cycles `dstrobe` is held high per op. Must be ≥4 so the 25 MHz write port samples it.
- `STROBE_LO`, default 4: cycles `dstrobe` is held low after each high phase.
- `ROWS`, default 30: text rows.
- `COLS`, default 80: text columns.

Ports:
- `clk` in 1: 100 MHz clock. Single clock domain.
- `reset_n` in 1: reset, synchronous, active-low.
- `in_data` in 8: input byte.
- `in_valid` in 1: `in_data` is valid.
- `in_ready` out 1: controller accepts a byte this cycle.
- `data` out 8: byte to the terminal core.
- `dtype` out 2: op type. 0 = char write, 1 = column, 2 = row.
- `dstrobe` out 1: write strobe. The core acts on its rising edge.
- `busy` out 1: an op sequence is in progress.
- `row` out 5: shadow cursor row.
- `col` out 7: shadow cursor column.

## Operation
- **Byte transfer:** a byte is transferred on a clock edge where `in_valid` and `in_ready` are both high.
- **`in_ready`:** high only in IDLE, ESC_ROW and ESC_COL.
- **States:**
  - INIT → IDLE
  - IDLE → EXEC or ESC_ROW
  - ESC_ROW → ESC_COL
  - ESC_COL → EXEC
  - EXEC → IDLE
  - EXEC(clear) loops internally and then → IDLE
- **INIT** (entered on reset): issue row←0, then col←0. Shadow cursor = (0,0).
- **Byte decoding in IDLE:**
  - 0x20–0x7E and 0x80–0xFF: one char write (dtype 0, data = byte). Shadow col increments. At col COLS-1 it wraps to 0 and row increments; at row ROWS-1 row wraps to 0. This matches the core's auto-advance.
  - 0x0D (CR): col←0.
  - 0x0A (LF): row←(row+1) mod ROWS. Column unchanged.
  - 0x08 (BS):
    - if col>0: col←col-1, char 0x20, col←col-1 (three ops).
    - if col=0: no op. The byte is accepted and `in_ready` stays high.
  - 0x09 (HT): col←min((col|7)+1, COLS-1).
  - 0x0C (FF): row←0, col←0, then ROWS×COLS (2400) char writes of 0x20, then row←0, col←0. Uses a 12-bit counter.
  - 0x1B (ESC): go to ESC_ROW. No op is issued.
  - All other codes 0x00–0x1F and 0x7F: accepted and ignored.
- **Escape sequence:**
  - ESC_ROW: the next byte r is latched and clamped to min(r, ROWS-1).
  - ESC_COL: the next byte c is clamped to min(c, COLS-1). Then ops row←r, col←c are issued.
  - No interpretation of control codes happens inside the escape sequence.
- **Shadow cursor:** updates when each op's strobe rises. `row` and `col` always equal the core's cursor after INIT completes.

## Timing
- **Op timing:** each op takes 1 + STROBE_HI + STROBE_LO cycles:
  - SETUP: `data`/`dtype` driven, `dstrobe` = 0.
  - HI: `dstrobe` = 1.
  - LO: `dstrobe` = 0.
  - `data`/`dtype` stay stable from SETUP through the end of LO.
- **Back-to-back ops:** the next op's SETUP directly follows the previous LO. `dstrobe` never rises without a preceding SETUP cycle.
- **Latency:** for a byte accepted at edge T:
  - SETUP is at T+1.
  - `dstrobe` is high T+2..T+1+STROBE_HI.
  - `in_ready` returns at T+2+STROBE_HI+STROBE_LO+9·(n-1) for n ops (defaults: T+10 for one op).
- **No-op bytes** (ignored codes, ESC, escape row byte, BS at col 0): `in_ready` stays high. Back-to-back acceptance every cycle.
- **`busy`:** high in INIT and EXEC, low otherwise.
- **Reset values:**
  - `dstrobe`=0, `data`=0, `dtype`=0, `in_ready`=0, `busy`=1, `row`=0, `col`=0.
  - INIT starts on the first cycle after `reset_n` deasserts. `in_ready` rises after 2 ops (18 cycles).
- **Reset mid-op:** `dstrobe` is 0 from the next edge. Any partial clear or escape sequence is abandoned and INIT reruns.
- **`in_valid` while `in_ready`=0:** ignored. The source must hold the byte.

## Test plan
- **Reset:** release `reset_n` → `dtype`=2/`data`=0 pulse, then `dtype`=1/`data`=0 pulse. `in_ready` is high at cycle 19, `row`=`col`=0.
- **Print:** send 0x41 at T → `data`=0x41, `dtype`=0 at T+1. `dstrobe` high T+2..T+5. `in_ready` at T+10. `col`=1.
- **Wrap:** ESC,29,79 then 0x42 → one char write. `row`=0, `col`=0.
- **Editing codes:**
  - at col 5, send BS → ops col=4, char 0x20, col=4.
  - at col 0, send BS → no strobe.
  - at col 10, send HT → col=16.
  - at col 78, send HT → col=79.
- **Clear:** send FF → exactly 2404 `dstrobe` rising edges: 2400 with `dtype`=0/`data`=0x20. Final ops row=0 and col=0. `busy` drops after 2404·9 cycles.
- **Clamp and reset:**
  - ESC,40,200 → row=29, col=79.
  - assert `reset_n` low during a clear → `dstrobe` is 0 next cycle, then INIT reruns.
